// File: rtl/shift_register_arbiter.sv
// Round-robin sequencer sharing one external 5-stage 8-bit delay line; SHIFT_REGISTER_ARBITER_FIXED_PRIO_EN selects fixed priority.
// Latency: 5 advancing cycles from grant to out_valid; out_valid && !out_ready freezes the whole line and withholds grants.
module shift_register_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DEPTH   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           sr_d,
  output logic                 sr_enable,
  output logic                 sr_reset,
  input  logic [7:0]           sr_q,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  output logic [ID_W-1:0]      out_id,
  input  logic                 out_ready,
  output logic [2:0]           inflight
);

  logic [DEPTH:1]  vld;
  logic [ID_W-1:0] id [1:DEPTH];
  logic            adv;
  logic            grant_any;
  logic            take;
  logic [ID_W-1:0] grant_idx;
  logic [7:0]      grant_dat;
  logic [2:0]      inflight_nxt;
`ifndef SHIFT_REGISTER_ARBITER_FIXED_PRIO_EN
  logic [ID_W-1:0] rr_ptr;
`endif

  // The delay line only moves when stage 5 is empty or being consumed.
  assign adv  = reset && (!vld[DEPTH] || out_ready);
  assign take = adv && grant_any;

  always_comb begin
    int              idx;
    logic [ID_W-1:0] cand;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef SHIFT_REGISTER_ARBITER_FIXED_PRIO_EN
      idx = k;
`else
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
`endif
      cand = ID_W'(idx);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    grant_dat = 8'h00;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_any && (grant_idx == ID_W'(i))) begin
        grant_dat    = req_data[8*i +: 8];
        req_ready[i] = adv;
      end
    end
  end

  assign sr_enable = adv;
  assign sr_d      = take ? grant_dat : 8'h00;
  assign sr_reset  = ~reset;

  assign out_valid = vld[DEPTH];
  assign out_data  = sr_q;
  assign out_id    = id[DEPTH];

  // Stage 5 always leaves on an advance, so the new count is stages 1..4 plus the entrant.
  always_comb begin
    inflight_nxt = 3'd0;
    for (int k = 1; k < DEPTH; k++) begin
      inflight_nxt = inflight_nxt + 3'(vld[k]);
    end
    inflight_nxt = inflight_nxt + 3'(take);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld      <= '0;
      inflight <= 3'd0;
      for (int k = 1; k <= DEPTH; k++) begin
        id[k] <= '0;
      end
    end else if (adv) begin
      vld      <= {vld[DEPTH-1:1], take};
      inflight <= inflight_nxt;
      id[1]    <= take ? grant_idx : '0;
      for (int k = 2; k <= DEPTH; k++) begin
        id[k] <= id[k-1];
      end
    end
  end

`ifndef SHIFT_REGISTER_ARBITER_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (take) begin
      rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_shift_register_arbiter.sv
// Self-checking bench: external delay line modelled here, DUT checked against an arrival-time scoreboard.
module tb_shift_register_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [31:0]  req_data;
  logic [3:0]   req_ready;
  logic [7:0]   sr_d;
  logic         sr_enable;
  logic         sr_reset;
  logic [7:0]   sr_q;
  logic         out_valid;
  logic [7:0]   out_data;
  logic [1:0]   out_id;
  logic         out_ready;
  logic [2:0]   inflight;

  always #5 clk = ~clk;

  shift_register_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DEPTH(5)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .sr_d(sr_d), .sr_enable(sr_enable), .sr_reset(sr_reset),
    .sr_q(sr_q), .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .out_ready(out_ready), .inflight(inflight)
  );

  // External 5-stage shift register
  logic [7:0] line [1:5];
  always @(posedge clk) begin
    if (sr_reset) begin
      for (int k = 1; k <= 5; k++) line[k] <= 8'h00;
    end else if (sr_enable) begin
      line[1] <= sr_d;
      for (int k = 2; k <= 5; k++) line[k] <= line[k-1];
    end
  end
  assign sr_q = line[5];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each accepted word is stamped with the advance count at acceptance;
  // it is visible once four further advances have happened.
  typedef struct { logic [7:0] d; int id; int stamp; } ent_t;
  ent_t q[$];
  int   m_ptr     = 0;
  int   adv_total = 0;
  bit   m_init    = 0;
  bit   head_vis;
  bit   exp_adv;
  int   exp_g;

  function automatic int pick(input logic [3:0] v, input int ptr);
`ifdef SHIFT_REGISTER_ARBITER_FIXED_PRIO_EN
    ptr = 0;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(ptr + k) % NUM_REQ] === 1'b1) return (ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic sample_and_check();
    @(negedge clk);
    head_vis = (q.size() > 0) && (adv_total - q[0].stamp == 4);
    exp_adv  = (reset === 1'b1) && !(head_vis && !out_ready);
    exp_g    = exp_adv ? pick(req_valid, m_ptr) : -1;
    chk("req_ready", req_ready, (exp_g >= 0) ? (32'd1 << exp_g) : 32'd0);
    chk("sr_enable", sr_enable, exp_adv);
    chk("sr_d", sr_d, (exp_g >= 0) ? req_data[8*exp_g +: 8] : 8'h00);
    chk("sr_reset", sr_reset, !reset);
    if (m_init) begin
      chk("out_valid", out_valid, head_vis);
      chk("out_data", out_data, head_vis ? q[0].d : 8'h00);
      if (head_vis) chk("out_id", out_id, q[0].id);
      chk("inflight", inflight, q.size());
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (reset !== 1'b1) begin
      q.delete();
      m_ptr  = 0;
      m_init = 1;
    end else if (exp_adv) begin
      adv_total++;
      if (head_vis) void'(q.pop_front());
      if (exp_g >= 0) begin
        q.push_back('{d: req_data[8*exp_g +: 8], id: exp_g, stamp: adv_total});
        m_ptr = (exp_g + 1) % NUM_REQ;
      end
    end
    #1;
  endtask

  task automatic step();
    sample_and_check();
    advance();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) step();
    reset = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 4'b1111;
    req_data  = 32'hDEADBEEF;
    out_ready = 1'b1;
    step();
    step();
    chk("rst_out_id", out_id, 0);
    chk("rst_out_valid", out_valid, 0);
    reset     = 1'b1;
    req_valid = 4'b0000;

    // Single word, no stall
    req_valid = 4'b0001;
    req_data[7:0] = 8'hA5;
    sample_and_check();
    chk("t1_grant", req_ready, 4'b0001);
    advance();
    req_valid = 4'b0000;
    repeat (4) begin
      chk("t1_early", out_valid, 0);
      step();
    end
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 8'hA5);
    chk("t1_id", out_id, 0);
    step();
    chk("t1_after", out_valid, 0);

    // Round-robin fairness
    do_reset(1);
    req_valid = 4'b1111;
    req_data  = 32'h13121110;
    for (int k = 0; k < 12; k++) begin
      sample_and_check();
`ifndef SHIFT_REGISTER_ARBITER_FIXED_PRIO_EN
      chk("rr_grant", req_ready, 32'd1 << (k % 4));
      if (k >= 5) begin
        chk("rr_data", out_data, 8'h10 + 8'((k - 5) % 4));
        chk("rr_id", out_id, (k - 5) % 4);
      end
`endif
      advance();
    end
    req_valid = 4'b0000;
    repeat (8) step();

    // Backpressure
    for (int w = 1; w <= 5; w++) begin
      req_valid = 4'b0001;
      req_data[7:0] = 8'(w);
      step();
    end
    req_data[7:0] = 8'h06;
    out_ready = 1'b0;
    repeat (3) begin
      sample_and_check();
      chk("bp_data", out_data, 8'h01);
      chk("bp_ready", req_ready, 4'b0000);
      chk("bp_enable", sr_enable, 0);
      chk("bp_inflight", inflight, 5);
      advance();
    end
    out_ready = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      sample_and_check();
      chk("bp_drain_valid", out_valid, 1);
      chk("bp_drain_data", out_data, j);
      advance();
      if (exp_g >= 0) req_valid[exp_g] = 1'b0;
    end
    req_valid = 4'b0000;
    repeat (8) step();

    // Bubble alignment
    req_valid = 4'b0010;
    req_data[15:8] = 8'h11;
    step();
    req_valid = 4'b0000;
    step();
    req_valid = 4'b0100;
    req_data[23:16] = 8'h22;
    step();
    req_valid = 4'b0000;
    step();
    step();
    chk("bub_v5", out_valid, 1);
    chk("bub_id5", out_id, 1);
    chk("bub_d5", out_data, 8'h11);
    step();
    chk("bub_v6", out_valid, 0);
    step();
    chk("bub_v7", out_valid, 1);
    chk("bub_id7", out_id, 2);
    chk("bub_d7", out_data, 8'h22);
    repeat (4) step();

    // Reset mid-flight
    req_valid = 4'b0001;
    req_data[7:0] = 8'h77;
    repeat (3) step();
    req_valid = 4'b0000;
    reset = 1'b0;
    sample_and_check();
    chk("mr_sr_reset", sr_reset, 1);
    advance();
    reset = 1'b1;
    chk("mr_inflight", inflight, 0);
    repeat (6) begin
      chk("mr_quiet", out_valid, 0);
      step();
    end
    req_valid = 4'b1010;
    req_data  = 32'h3C2B1A09;
    sample_and_check();
    chk("mr_first", req_ready, 4'b0010);
    advance();
    if (exp_g >= 0) req_valid[exp_g] = 1'b0;
    repeat (3) step();

`ifdef SHIFT_REGISTER_ARBITER_FIXED_PRIO_EN
    do_reset(1);
    req_valid = 4'b1010;
    repeat (10) begin
      sample_and_check();
      chk("fp_grant", req_ready, 4'b0010);
      advance();
    end
`endif

    // Randomized traffic, stalls and occasional reset
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 199) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 2) == 0)) begin
          req_valid[i]        = 1'b1;
          req_data[8*i +: 8]  = 8'($urandom);
        end
      end
      step();
      if (exp_g >= 0) req_valid[exp_g] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shift_register_arbiter.md
Name: shift_register_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one external 5-stage, 8-bit shift_register delay line among NUM_REQ requesters.
- Drives the shift register's D, enable and reset.
- Keeps a parallel valid/ID pipeline aligned with the 5 data stages, so every word leaves the delay line tagged with its requester.
- Applies output backpressure by stalling the entire delay line.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must equal clog2(NUM_REQ).
- DEPTH, 5, delay-line stage count; fixed to the shift register's depth.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-low.
- req_valid  input  NUM_REQ  per-requester data valid.
- req_data  input  8*NUM_REQ  requester i data in bits [8i+7:8i].
- req_ready  output  NUM_REQ  one-hot grant; transfer occurs when req_valid[i] && req_ready[i].
- sr_d  output  8  to shift register D.
- sr_enable  output  1  to shift register enable.
- sr_reset  output  1  to shift register reset (active-high); equals ~reset.
- sr_q  input  8  from shift register Q (stage 5).
- out_valid  output  1  stage-5 word valid.
- out_data  output  8  equals sr_q.
- out_id  output  ID_W  requester ID of the stage-5 word.
- out_ready  input  1  downstream accepts the word.
- inflight  output  3  count of valid words across the 5 stages (0..5).

Behaviour:
- State registers:
  - vld[1..5] and id[1..5] mirror the delay-line stages.
  - rr_ptr (ID_W) holds the highest-priority requester index.
- Reset: on a clk edge with reset==0:
  - vld, id and rr_ptr all go to 0.
  - While reset==0: req_ready=0, sr_enable=0, sr_d=0, and sr_reset=1 clears the delay line.
  - out_valid=0, out_id=0, inflight=0; out_data=0 via the cleared sr_q.
- Advance: adv = reset && (!vld[5] || out_ready). When adv=0, the line holds and every output is stable.
- Arbitration, combinational, only when adv=1:
  - Grant goes to the first asserted req_valid searching from rr_ptr upward with wrap-around.
  - req_ready is the one-hot grant, or 0 when there is no request or adv=0.
- Shift, combinational controls:
  - sr_enable = adv.
  - sr_d = granted requester's data, else 8'h00 (bubble).
- Shift, on each adv edge:
  - vld[1] <= grant_any; id[1] <= granted index; vld/id[k] <= vld/id[k-1] for k = 2..5.
  - On grant, rr_ptr <= (winner+1) mod NUM_REQ.
  - Without a grant, rr_ptr is unchanged.
- Latency: a word accepted on advancing edge E0 appears with out_valid=1 after 4 further advancing edges, i.e. 5 cycles later when unstalled. Stalls add cycle-for-cycle.
- Throughput: one word per cycle when out_ready=1 continuously. Bubbles are inserted in idle cycles.
- Simultaneous events:
  - A stage-5 pop and a new grant in the same cycle are both legal.
  - inflight is unchanged when a valid word enters while a valid word leaves.
- inflight = popcount(vld[1..5]); registered, updated with the pipeline.
- Stall: when out_valid=1 and out_ready=0, all stages hold, req_ready=0, and out_data/out_id stay stable until accepted.
- Reset mid-operation: all in-flight words are discarded and no out_valid appears afterward. The first post-reset grant goes to requester 0 if it is requesting.
- Requester handshake: a requester keeps req_valid and req_data stable until granted; no drop rule is enforced.

Optional Feature:
- Macro SHIFT_REGISTER_ARBITER_FIXED_PRIO_EN.
- Defined: fixed priority, lowest asserted index wins; rr_ptr is removed, or held at 0.
- Undefined (default): round-robin as specified above.

Test Plan:
- Single word, no stall: reset low 2 cycles, then req_valid=4'b0001 with data 8'hA5 for 1 cycle, out_ready=1 → req_ready[0] in that cycle; out_valid=1, out_data=8'hA5, out_id=0 exactly 5 cycles later, for 1 cycle.
- Round-robin fairness: req_valid=4'b1111 held, data i = 8'h10+i, out_ready=1 → grants in order 0,1,2,3,0,1…; outputs 8'h10,11,12,13 with IDs 0..3 on consecutive cycles starting 5 cycles after the first grant.
- Backpressure: fill with 8'h01..8'h05, then out_ready=0 for 3 cycles → out_data=8'h01 held, req_ready=0, sr_enable=0, inflight=5; release → 8'h01..8'h05 drain in order with no loss or duplication.
- Bubble alignment: requests in cycles 0 and 2 only (8'h11 from req 1, 8'h22 from req 2) → out_valid in cycles 5 and 7 with IDs 1 and 2; cycle 6 has out_valid=0.
- Reset mid-flight: 3 words in flight, reset low 1 cycle → sr_reset=1, inflight=0, and no out_valid for the next 6 cycles without new requests; a post-reset req_valid=4'b1010 is granted to requester 1 first.
- Macro defined, req_valid=4'b1010 held → requester 1 granted every cycle, requester 3 never granted.
